// File: rtl/mul_seq_ctrl.sv
// Sequential repeated-addition multiplier: a four-state controller drives the A/B/P datapath.
// Optional build macro EARLY_ZERO_EN: CALC also exits when A == 0.
module mul_seq_ctrl #(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   din,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product,
   output logic           eqz
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOADB = 2'd1,
      S_CALC  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
   } dp_t;

   state_t state_q, state_d;
   dp_t    dp_q, dp_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;
   logic   calc_exit;

   assign eqz = (dp_q.b == '0);

`ifdef EARLY_ZERO_EN
   assign calc_exit = eqz | (dp_q.a == '0);
`else
   assign calc_exit = eqz;
`endif

   always_comb begin
      state_d = state_q;
      dp_d    = dp_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dp_d.a  = din;
               state_d = S_LOADB;
            end
         end
         S_LOADB: begin
            dp_d.b  = din;
            dp_d.p  = '0;
            state_d = S_CALC;
         end
         S_CALC: begin
            if (calc_exit) begin
               state_d = S_DONE;
            end else begin
               // B only counts down while non-zero, so it never wraps
               dp_d.p = dp_q.p + {{W{1'b0}}, dp_q.a};
               dp_d.b = dp_q.b - 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // status flags are registered alongside the state they describe
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         dp_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dp_q    <= dp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = dp_q.p;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized self-checking bench for mul_seq_ctrl against a latency/product reference model.
module tb_mul_seq_ctrl;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   din;
   logic           busy, done, eqz;
   logic [2*W-1:0] product;

   int errors = 0;
   int checks = 0;

   mul_seq_ctrl #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .din(din),
      .busy(busy), .done(done), .product(product), .eqz(eqz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: product is A*B; done arrives N+3 cycles after start (3 if A==0 in early build).
   function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef EARLY_ZERO_EN
      if (a == 0) return 3;
`endif
      return int'(b) + 3;
   endfunction

   // Wait from cycle t+2 for done; returns the cycle offset at which it was seen.
   task automatic wait_done(input int lat, input bit chk_eqz, output int cyc);
      @(negedge clk);
      cyc = 2;
      din = W'($urandom);
      while (!done && cyc < lat + 8) begin
         if (chk_eqz) chk("eqz_calc", 64'(eqz), 64'd1);
         @(negedge clk);
         cyc++;
         din = W'($urandom);
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit chk_eqz);
      int lat, cyc;
      logic [2*W-1:0] expp;
      expp = (2*W)'(a) * (2*W)'(b);
      lat  = ref_lat(a, b);
      @(negedge clk);
      start = 1'b1; din = a;
      @(negedge clk);
      chk({tag, "_busy_t1"}, 64'(busy), 64'd1);
      start = 1'b0; din = b;
      wait_done(lat, chk_eqz, cyc);
      chk({tag, "_latency"}, 64'(cyc), 64'(lat));
      chk({tag, "_product"}, 64'(product), 64'(expp));
      @(negedge clk);
      chk({tag, "_done_low"}, 64'(done), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      chk({tag, "_held"}, 64'(product), 64'(expp));
   endtask

   initial begin
      int cyc, pulses;
      logic [W-1:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; din = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_product", 64'(product), 64'd0);
      chk("rst_eqz", 64'(eqz), 64'd1);
      rst_n = 1'b1;

      run_op("5x3", 16'd5, 16'd3, 1'b0);
      run_op("ffffx2", 16'hFFFF, 16'd2, 1'b0);
      run_op("7x0", 16'd7, 16'd0, 1'b1);
      run_op("0xffff", 16'd0, 16'hFFFF, 1'b0);

      // Start pulses in CALC and DONE must be ignored; first IDLE cycle accepts.
      @(negedge clk); start = 1'b1; din = 16'd4;
      @(negedge clk); start = 1'b0; din = 16'd4;
      @(negedge clk); din = '0;
      @(negedge clk); start = 1'b1; din = 16'd9;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy4_done", 64'(done), 64'd1);
      chk("busy4_product", 64'(product), 64'd16);
      start = 1'b1; din = 16'd9;
      @(negedge clk);
      chk("busy4_idle", 64'(busy), 64'd0);
      chk("busy4_held", 64'(product), 64'd16);
      start = 1'b1; din = 16'd2;
      @(negedge clk);
      chk("restart_busy", 64'(busy), 64'd1);
      start = 1'b0; din = 16'd5;
      wait_done(ref_lat(16'd2, 16'd5), 1'b0, cyc);
      chk("restart_latency", 64'(cyc), 64'(ref_lat(16'd2, 16'd5)));
      chk("restart_product", 64'(product), 64'd10);

      // Reset in the middle of CALC aborts without a done pulse.
      repeat (2) @(negedge clk);
      start = 1'b1; din = 16'd10;
      @(negedge clk); start = 1'b0; din = 16'd10;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_product", 64'(product), 64'd0);
      pulses = 0;
      repeat (120) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("abort_no_done", 64'(pulses), 64'd0);
      run_op("2x3", 16'd2, 16'd3, 1'b0);

      for (int i = 0; i < 10; i++) begin
         ra = (i % 4 == 3) ? 16'd0 : W'($urandom);
         rb = W'($urandom_range(0, 24));
         run_op($sformatf("rnd%0d", i), ra, rb, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
